uart_hex_display: RTL
=====================

// Module: uart_hex_display
// PURPOSE
//  Parametrised UART-to-seven-segment front end. Contains a UART receiver (framing-error detect,
//  break handling) and a store of NUM_BYTES received bytes, shown as 2*NUM_BYTES hex digits.
//  Two modes: latch-newest or shift-history. Optional idle blanking timeout.
//  Sits at board top between the RX pin and the segment pins.
// PARAMETERS
//  CLKS_PER_BIT  217  clocks per UART bit (25 MHz / 115200); >= 4
//  NUM_BYTES     2    bytes stored/displayed; 1..4; digit count = 2*NUM_BYTES
//  BLANK_CLKS    0    idle clocks before all digits blank; 0 = blanking disabled
// PORTS
//  i_Clk          in   1              system clock; all logic on rising edge
//  i_Reset        in   1              synchronous, active-high reset
//  i_RX_Serial    in   1              async UART line, idle high, 8N1, LSB first
//  i_Mode         in   1              0 = latch newest into slot 0; 1 = shift history
//  o_Byte         out  8              last good byte
//  o_Byte_Valid   out  1              1-cycle pulse, o_Byte valid
//  o_Frame_Err    out  1              sticky: last frame had stop bit = 0
//  o_Seg          out  14*NUM_BYTES   active-low segments; digit d at [7d+6:7d], bit0=A..bit6=G
// BEHAVIOUR
//  - Reset: FSM IDLE; o_Byte=0, o_Byte_Valid=0, o_Frame_Err=0; all slots 0 -> every digit 7'h40 ("0");
//    blank counter 0, not blanked. Reset mid-frame aborts frame; no o_Byte_Valid for it.
//  - i_RX_Serial through 2-FF synchroniser (preset to 1 on reset) before any use.
//  - RX FSM: IDLE -> START on synced low. START: at CLKS_PER_BIT/2 re-sample; low -> DATA, high
//    (glitch) -> IDLE. DATA: sample every CLKS_PER_BIT, 8 bits LSB first. STOP: sample after
//    CLKS_PER_BIT; 1 -> good frame, 0 -> frame error. CLEANUP: wait until synced line high -> IDLE
//    (held-low break yields exactly one frame error, no repeated frames).
//  - Good frame: o_Byte updated and o_Byte_Valid pulses on the cycle after the stop sample;
//    o_Frame_Err cleared same cycle. Frame error: o_Frame_Err=1, no pulse, store untouched.
//  - Store update on the cycle after o_Byte_Valid (o_Seg combinational from store):
//    mode 0: slot0 <= byte, other slots held; mode 1: slot k <= slot k-1, slot0 <= byte.
//    i_Mode sampled only at update; a mid-frame change affects only that update.
//  - Digit map: digit 2k = slot k low nibble, digit 2k+1 = slot k high nibble; digit 0 rightmost.
//  - Hex encode (G..A): 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E.
//  - Blanking (BLANK_CLKS>0): counter increments each cycle and saturates at BLANK_CLKS; at
//    saturation all digits 7'h7F. Good byte resets counter to 0 and unblanks in its update cycle.
//    Frame errors do not reset the counter. Width $clog2(BLANK_CLKS+1).
//  - Bit-timing counter width $clog2(CLKS_PER_BIT); bit index 3 bits, wraps only via state exit.
//  - Line-to-display latency: stop-bit sample + 2 clocks.
// STRUCTURE
//  - Package uart_disp_pkg: RX state enum (IDLE, START, DATA, STOP, CLEANUP), segment constants
//    SEG_BLANK=7'h7F, function hex_to_seg(nibble) implementing the table above.
//  - Sub-module uart_rx_core (CLKS_PER_BIT): synchroniser + FSM, outputs byte, valid, frame_err.
//  - Top holds store, mode mux, blank counter, NUM_BYTES*2 hex_to_seg instances via generate.
// TESTING (bench: CLKS_PER_BIT=8, NUM_BYTES=2, BLANK_CLKS=200 unless stated)
//  1 Reset, line high -> o_Seg = {4{7'h40}}, o_Frame_Err=0, o_Byte_Valid never pulses.
//  2 Mode 0, send 0x3A -> one pulse, o_Byte=0x3A; digits1..0 = 7'h30,7'h08; digits3..2 stay 7'h40.
//  3 Mode 1, send 0x12 then 0x34 -> digits3..0 = 1,2,3,4 (79,24,30,19); mode 0 then 0xFF -> 1,2,F,F.
//  4 Line low 2 clocks then high -> no pulse, FSM back to IDLE, display unchanged.
//  5 Frame 0x55 with stop=0, line held low 3 bit times -> o_Frame_Err=1 once, no pulse, display
//    unchanged; then good 0xA5 -> pulse, o_Frame_Err=0, digits1..0 = A,5.
//  6 No traffic 200 clocks -> all 7'h7F; send 0x00 -> digits unblank; i_Reset mid-data-bits -> no
//    pulse, all digits 7'h40, next good frame received normally.

Source files
------------

// File: rtl/uart_disp_pkg.sv
// Shared types and helpers for the UART hex display front end.
// Holds the receiver state encoding and the segment encoder.
package uart_disp_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        CLEANUP
    } rx_state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low segments, bit0 = A .. bit6 = G
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        unique case (nib)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            4'hF: seg = 7'h0E;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver with input synchroniser, framing-error flag
// and break handling (a held-low line reports one error only).
module uart_rx_core
    import uart_disp_pkg::*;
#(
    parameter int CLKS_PER_BIT = 217
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       serial,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

    logic [1:0]    sync;
    logic          line;
    rx_state_t     state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    idx, idx_n;
    logic [7:0]    shreg, shreg_n;
    logic [7:0]    data_n;
    logic          valid_n, err_n;

    assign line = sync[1];

    always_ff @(posedge clk) begin
        if (reset) begin
            sync      <= 2'b11;
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            shreg     <= '0;
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            sync      <= {sync[0], serial};
            state     <= state_n;
            cnt       <= cnt_n;
            idx       <= idx_n;
            shreg     <= shreg_n;
            data      <= data_n;
            valid     <= valid_n;
            frame_err <= err_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        shreg_n = shreg;
        data_n  = data;
        valid_n = 1'b0;
        err_n   = frame_err;
        unique case (state)
            IDLE: begin
                cnt_n = '0;
                idx_n = '0;
                if (!line) state_n = START;
            end
            START: begin
                if (cnt == HALF) begin
                    cnt_n   = '0;
                    state_n = line ? IDLE : DATA;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            DATA: begin
                if (cnt == LAST) begin
                    cnt_n   = '0;
                    shreg_n = {line, shreg[7:1]};
                    idx_n   = idx + 1'b1;
                    if (idx == 3'd7) state_n = STOP;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            STOP: begin
                if (cnt == LAST) begin
                    cnt_n   = '0;
                    state_n = CLEANUP;
                    if (line) begin
                        data_n  = shreg;
                        valid_n = 1'b1;
                        err_n   = 1'b0;
                    end else begin
                        err_n = 1'b1;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            // Stay here through a break until the line recovers
            CLEANUP: begin
                if (line) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: rtl/uart_hex_display.sv
// UART receiver feeding a byte store shown as hex on 7-seg digits,
// with latch/shift modes and optional idle blanking.
module uart_hex_display
    import uart_disp_pkg::*;
#(
    parameter int CLKS_PER_BIT = 217,
    parameter int NUM_BYTES    = 2,
    parameter int BLANK_CLKS   = 0
) (
    input  logic                    i_Clk,
    input  logic                    i_Reset,
    input  logic                    i_RX_Serial,
    input  logic                    i_Mode,
    output logic [7:0]              o_Byte,
    output logic                    o_Byte_Valid,
    output logic                    o_Frame_Err,
    output logic [14*NUM_BYTES-1:0] o_Seg
);

    localparam int BW = (BLANK_CLKS > 0) ? $clog2(BLANK_CLKS + 1) : 1;
    localparam logic [BW-1:0] BLANK_MAX = BW'(BLANK_CLKS);

    logic [7:0]    slots [NUM_BYTES];
    logic [BW-1:0] idle_cnt;
    logic          blanked;

    uart_rx_core #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) rx (
        .clk      (i_Clk),
        .reset    (i_Reset),
        .serial   (i_RX_Serial),
        .data     (o_Byte),
        .valid    (o_Byte_Valid),
        .frame_err(o_Frame_Err)
    );

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            for (int k = 0; k < NUM_BYTES; k++) slots[k] <= '0;
            idle_cnt <= '0;
        end else if (o_Byte_Valid) begin
            if (i_Mode) begin
                for (int k = 1; k < NUM_BYTES; k++) slots[k] <= slots[k-1];
            end
            slots[0] <= o_Byte;
            idle_cnt <= '0;
        end else if (BLANK_CLKS > 0 && idle_cnt != BLANK_MAX) begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end

    assign blanked = (BLANK_CLKS > 0) && (idle_cnt == BLANK_MAX);

    // Digit 2k shows the low nibble of slot k, digit 2k+1 the high nibble
    for (genvar d = 0; d < 2 * NUM_BYTES; d++) begin : g_digit
        logic [3:0] nib;
        assign nib = slots[d/2][4*(d%2) +: 4];
        assign o_Seg[7*d +: 7] = blanked ? SEG_BLANK : hex_to_seg(nib);
    end

endmodule
